// File: rtl/mem_copy_engine.sv
// Block copy / fill engine for the 8-bit x 256 data memory.
// Acts as memory bus initiator while busy; backward copy protects overlapping moves.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic [DW-1:0] fill_value,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, next_state;
  logic          mode_q;
  logic          step_down;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] buf_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] count;
  logic [AW:0]   src_end;
  logic          backward;

  // Overlap test uses an unwrapped end address, so blocks straddling the top copy forward
  assign src_end  = {1'b0, src_addr} + {1'b0, length};
  assign backward = ~mode & (dst_addr > src_addr) & ({1'b0, dst_addr} < src_end);

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Bus outputs depend on registered state only; start only steers the next state
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) next_state = DONE;
          else if (mode)    next_state = WRITE;
          else              next_state = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_addr   = rd_ptr;
        next_state = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = wr_ptr;
        mem_we    = 1'b1;
        mem_wdata = mode_q ? fill_q : buf_q;
        if (count == AW'(1)) next_state = DONE;
        else if (mode_q)     next_state = WRITE;
        else                 next_state = READ;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      mode_q    <= 1'b0;
      step_down <= 1'b0;
      fill_q    <= '0;
      buf_q     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            fill_q    <= fill_value;
            count     <= length;
            step_down <= backward;
            if (backward) begin
              rd_ptr <= src_addr + length - AW'(1);
              wr_ptr <= dst_addr + length - AW'(1);
            end else begin
              rd_ptr <= src_addr;
              wr_ptr <= dst_addr;
            end
          end
        end
        READ: begin
          buf_q  <= mem_rdata;
          rd_ptr <= step_down ? rd_ptr - AW'(1) : rd_ptr + AW'(1);
        end
        WRITE: begin
          wr_ptr <= step_down ? wr_ptr - AW'(1) : wr_ptr + AW'(1);
          count  <= count - AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random transfers
// compared against a byte-by-byte reference of the transfer rules.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       mode;
  logic [7:0] src_addr, dst_addr, length, fill_value;
  logic       busy, done, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wr_log[$];
  logic [7:0] exp_addrs[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_busy, exp_done_cyc;
  int obs_busy, obs_done_cnt, obs_done_cyc, obs_we_err;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk(clk), .Reset(Reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back(mem_addr);
    end
  end

  // Reference: the transfer as a plain sequence of byte moves, in the order the rules define
  task automatic model_xfer(input logic m, input logic [7:0] s, d, l, f);
    logic       back;
    logic [7:0] ra, wa;
    int         n;
    n    = int'(l);
    back = (m == 1'b0) && (d > s) && (int'(d) < int'(s) + n);
    exp_addrs.delete();
    for (int i = 0; i < n; i++) begin
      ra = back ? 8'(int'(s) + n - 1 - i) : 8'(int'(s) + i);
      wa = back ? 8'(int'(d) + n - 1 - i) : 8'(int'(d) + i);
      exp_addrs.push_back(wa);
      ref_mem[wa] = m ? f : ref_mem[ra];
    end
    exp_busy     = (n == 0) ? 0 : (m ? n : 2 * n);
    exp_done_cyc = exp_busy + 1;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic int addr_diff();
    int n = 0;
    if (wr_log.size() != exp_addrs.size()) return 1000 + wr_log.size();
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== exp_addrs[i]) n++;
    return n;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Launches one transfer, scrambles operands afterwards, and observes a fixed window
  task automatic run_xfer(input logic m, input logic [7:0] s, d, l, f, input int pulse_at);
    logic exp_we;
    int   win;
    model_xfer(m, s, d, l, f);
    @(negedge clk);
    wr_log.delete();
    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f; start = 1'b1;
    obs_busy = 0; obs_done_cnt = 0; obs_done_cyc = -1; obs_we_err = 0;
    win = exp_done_cyc + 3;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (busy === 1'b1) obs_busy++;
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      exp_we = (c <= exp_busy) && (m || (c % 2 == 0));
      if (mem_we !== exp_we) obs_we_err++;
      start      = (c == pulse_at);
      mode       = 1'($urandom);
      src_addr   = 8'($urandom);
      dst_addr   = 8'($urandom);
      length     = 8'($urandom_range(1, 9));
      fill_value = 8'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_checks++; if (mem_we !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_we got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_addr got %h want 00", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_wdata got %h want 00", mem_wdata); end
    Reset = 1'b0;
  endtask

  task automatic test_fill();
    run_xfer(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, -1);
    n_checks++; if (obs_busy !== 4)     begin n_fail++; $display("[TB] FAIL fill_busy got %0d want 4", obs_busy); end
    n_checks++; if (obs_done_cyc !== 5) begin n_fail++; $display("[TB] FAIL fill_done_cycle got %0d want 5", obs_done_cyc); end
    n_checks++; if (obs_we_err !== 0)   begin n_fail++; $display("[TB] FAIL fill_we_pattern got %0d bad cycles want 0", obs_we_err); end
    n_checks++; if (mem[8'h13] !== 8'hA5) begin n_fail++; $display("[TB] FAIL fill_byte got %h want a5", mem[8'h13]); end
    n_checks++; if (mem_diff() !== 0)   begin n_fail++; $display("[TB] FAIL fill_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_copy();
    @(negedge clk);
    poke(8'h20, 8'd1); poke(8'h21, 8'd2); poke(8'h22, 8'd3);
    run_xfer(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, -1);
    n_checks++; if (obs_busy !== 6)     begin n_fail++; $display("[TB] FAIL copy_busy got %0d want 6", obs_busy); end
    n_checks++; if (obs_done_cyc !== 7) begin n_fail++; $display("[TB] FAIL copy_done_cycle got %0d want 7", obs_done_cyc); end
    n_checks++; if (obs_we_err !== 0)   begin n_fail++; $display("[TB] FAIL copy_we_pattern got %0d bad cycles want 0", obs_we_err); end
    n_checks++; if (mem[8'h42] !== 8'd3) begin n_fail++; $display("[TB] FAIL copy_byte got %h want 03", mem[8'h42]); end
    n_checks++; if (mem_diff() !== 0)   begin n_fail++; $display("[TB] FAIL copy_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_overlap();
    @(negedge clk);
    poke(8'h30, 8'd7); poke(8'h31, 8'd8); poke(8'h32, 8'd9);
    run_xfer(1'b0, 8'h30, 8'h31, 8'd3, 8'h00, -1);
    n_checks++; if (wr_log.size() !== 3 || wr_log[0] !== 8'h33 || wr_log[2] !== 8'h31)
      begin n_fail++; $display("[TB] FAIL overlap_order got %p want 33 32 31", wr_log); end
    n_checks++; if (mem[8'h33] !== 8'd9 || mem[8'h31] !== 8'd7)
      begin n_fail++; $display("[TB] FAIL overlap_bytes got %h/%h want 07/09", mem[8'h31], mem[8'h33]); end
    n_checks++; if (mem_diff() !== 0)   begin n_fail++; $display("[TB] FAIL overlap_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_wrap();
    logic [7:0] keep;
    keep = ref_mem[8'h01];
    run_xfer(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5C, -1);
    n_checks++; if (mem[8'h00] !== 8'h5C) begin n_fail++; $display("[TB] FAIL wrap_byte got %h want 5c", mem[8'h00]); end
    n_checks++; if (mem[8'h01] !== keep)  begin n_fail++; $display("[TB] FAIL wrap_neighbour got %h want %h", mem[8'h01], keep); end
    n_checks++; if (addr_diff() !== 0)    begin n_fail++; $display("[TB] FAIL wrap_addrs got %0d bad want 0", addr_diff()); end
    n_checks++; if (mem_diff() !== 0)     begin n_fail++; $display("[TB] FAIL wrap_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_zero_len();
    run_xfer(1'b0, 8'h55, 8'h66, 8'd0, 8'h00, -1);
    n_checks++; if (obs_done_cyc !== 1)  begin n_fail++; $display("[TB] FAIL zero_done_cycle got %0d want 1", obs_done_cyc); end
    n_checks++; if (obs_busy !== 0)      begin n_fail++; $display("[TB] FAIL zero_busy got %0d want 0", obs_busy); end
    n_checks++; if (wr_log.size() !== 0) begin n_fail++; $display("[TB] FAIL zero_writes got %0d want 0", wr_log.size()); end
  endtask

  task automatic test_busy_start();
    run_xfer(1'b1, 8'h00, 8'hA0, 8'd5, 8'h77, 2);
    n_checks++; if (obs_done_cnt !== 1) begin n_fail++; $display("[TB] FAIL busy_start_dones got %0d want 1", obs_done_cnt); end
    n_checks++; if (obs_busy !== 5)     begin n_fail++; $display("[TB] FAIL busy_start_busy got %0d want 5", obs_busy); end
    run_xfer(1'b0, 8'hB0, 8'hC0, 8'd2, 8'h00, 5);
    n_checks++; if (obs_done_cnt !== 1 || obs_busy !== 4)
      begin n_fail++; $display("[TB] FAIL done_start got dones=%0d busy=%0d want 1/4", obs_done_cnt, obs_busy); end
    n_checks++; if (mem_diff() !== 0)   begin n_fail++; $display("[TB] FAIL busy_start_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    wr_log.delete();
    mode = 1'b1; dst_addr = 8'h80; length = 8'd6; fill_value = 8'h3C; start = 1'b1;
    ref_mem[8'h80] = 8'h3C; ref_mem[8'h81] = 8'h3C;
    @(negedge clk); start = 1'b0;
    @(negedge clk); Reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mem_we !== 1'b0)
      begin n_fail++; $display("[TB] FAIL abort_idle got busy=%b we=%b want 0/0", busy, mem_we); end
    Reset = 1'b0;
    obs_done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || mem_we === 1'b1) obs_done_cnt++;
    end
    n_checks++; if (obs_done_cnt !== 0)  begin n_fail++; $display("[TB] FAIL abort_quiet got %0d active cycles want 0", obs_done_cnt); end
    n_checks++; if (wr_log.size() !== 2) begin n_fail++; $display("[TB] FAIL abort_writes got %0d want 2", wr_log.size()); end
    n_checks++; if (mem_diff() !== 0)    begin n_fail++; $display("[TB] FAIL abort_mem got %0d bad bytes want 0", mem_diff()); end
  endtask

  task automatic test_random();
    logic       m;
    logic [7:0] s, d, l;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom);
      s = 8'($urandom);
      d = (i % 3 == 0) ? 8'(s + $urandom_range(0, 6)) : 8'($urandom);
      l = (i == 5) ? 8'd255 : 8'($urandom_range(0, 20));
      run_xfer(m, s, d, l, 8'($urandom), -1);
      n_checks++; if (obs_done_cyc !== exp_done_cyc || obs_done_cnt !== 1 || obs_busy !== exp_busy)
        begin n_fail++; $display("[TB] FAIL rand%0d_timing got done@%0d x%0d busy=%0d want done@%0d x1 busy=%0d", i, obs_done_cyc, obs_done_cnt, obs_busy, exp_done_cyc, exp_busy); end
      n_checks++; if (obs_we_err !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_we got %0d bad cycles want 0", i, obs_we_err); end
      n_checks++; if (addr_diff() !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_addrs got %0d bad want 0", i, addr_diff()); end
      n_checks++; if (mem_diff() !== 0)  begin n_fail++; $display("[TB] FAIL rand%0d_mem got %0d bad bytes want 0", i, mem_diff()); end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    $display("[TB] starting mem_copy_engine tests");
    test_reset();
    test_fill();
    test_copy();
    test_overlap();
    test_wrap();
    test_zero_len();
    test_busy_start();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
